arbitro_mux_rr: RTL and testbench
=================================

Name: arbitro_mux_rr

Overview:
- Round-robin arbiter and sequencer for the 2:1 mux-with-memory datapath (2-bit lanes data_in0/data_in1, selector, registered 2-bit data_out).
- Shares the single registered output between two requesters using valid/ready handshakes, with bounded bursts.
- Drives selector so the downstream mux and monitors always know which lane owns data_out.
- Sits between the two 2-bit sources and the consumer of data_out.

Parameters:
- MAX_BURST, 4: maximum beats accepted from one requester per grant before the grant must be offered to the other; legal range 1..7.
- CNT_W, 3: width of the burst counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk, input, 1: single clock; all state updates on the posedge.
- reset, input, 1: asynchronous, active-high reset.
- valid_in0, input, 1: requester 0 has data.
- data_in0, input, 2: requester 0 data.
- ready0, output, 1: requester 0 beat accepted this cycle when valid_in0 is also high.
- valid_in1, input, 1: requester 1 has data.
- data_in1, input, 2: requester 1 data.
- ready1, output, 1: requester 1 beat accepted this cycle when valid_in1 is also high.
- ready_out, input, 1: consumer accepts data_out this cycle.
- valid_out, output, 1: data_out holds an unconsumed beat.
- data_out, output, 2: registered muxed data.
- selector, output, 1: source lane of the current grant (0 or 1).

Behaviour:
- Clocking and reset:
  - Single clock clk; asynchronous active-high reset.
  - While reset is high: state=IDLE, last_grant=1, burst_cnt=0, selector=0, data_out=2'b00, valid_out=0, ready0=ready1=0.
  - Reset asserted mid-burst clears everything immediately; any in-flight data_out beat is dropped.
- FSM states: IDLE, SERV0, SERV1.
- Ready outputs (combinational):
  - ready0 = (state==SERV0) && (!valid_out || ready_out).
  - ready1 is the same with SERV1. Both are 0 in IDLE.
- Accept (beat transfer):
  - Occurs when valid_inN && readyN.
  - Next cycle: data_out=data_inN, valid_out=1. Latency is exactly 1 cycle.
- Output register:
  - If ready_out=1 and there is no accept, valid_out goes to 0 next cycle and data_out holds its value.
  - If valid_out=1 and ready_out=0, data_out and valid_out are frozen.
- IDLE transitions:
  - Both valid: go to SERVk where k != last_grant.
  - One valid: go to that requester's SERV state.
  - None valid: stay in IDLE.
  - On entry to SERVk: selector<=k, last_grant<=k, burst_cnt<=0.
  - The IDLE->SERV cycle accepts nothing (one bubble).
- SERVn transitions (evaluated every cycle):
  - Each accept increments burst_cnt.
  - If an accept makes burst_cnt reach MAX_BURST: go to the other SERV state if its valid is high (no bubble). Otherwise stay and reset burst_cnt to 0.
  - If valid_inn=0 and there is no accept: go to the other SERV state if its valid is high, else IDLE.
  - Backpressure (ready_out=0 with valid_out=1) holds state and burst_cnt.
- selector changes only on entry to a SERV state and holds in IDLE.
- Simultaneous events: the accept of the last burst beat and the grant switch occur in the same edge. data_out always reflects the lane that owned selector when the beat was accepted.

Optional Feature:
- Macro: ARB_CONT_EN.
- Defined:
  - Adds outputs cont_grant0 and cont_grant1, 4 bits each.
  - Each counts accepted beats per requester and saturates at 4'b1111.
  - Both cleared by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Assert reset for 2 cycles with random inputs -> valid_out=0, data_out=00, selector=0, ready0=ready1=0. Release reset -> state IDLE.
2. Hold valid_in0=1 with data 01,10,11,00,01 and ready_out=1; valid_in1=0.
   - After the 1-cycle IDLE bubble, ready0 is continuously high.
   - data_out = 01,10,11,00,01, each 1 cycle after accept.
   - selector=0 throughout.
3. Hold both valids high with ready_out=1 and MAX_BURST=4 -> requester 0 gets 4 beats, then requester 1 gets 4 beats, alternating with no bubbles. selector toggles on the edge after each 4th accept.
4. Mid-burst, drive ready_out=0 for 3 cycles -> data_out and valid_out frozen, ready0=0, burst_cnt unchanged. Release -> the burst resumes and still totals 4 beats.
5. Assert reset asynchronously between edges during SERV1 -> outputs clear immediately. After release with both valid -> requester 0 is granted first.
6. With ARB_CONT_EN defined, run scenario 3 for 40 beats -> cont_grant0=cont_grant1=4'b1111 (saturated); without the macro, the bench compiles without those ports.

Source files
------------

// File: rtl/arbitro_mux_rr_if.sv
// Handshake bundle between the two 2-bit requesters, the arbiter and the data_out consumer.
// The cont_grant0/cont_grant1 lines exist only when ARB_CONT_EN is defined.
interface arbitro_mux_rr_if;
   logic       valid_in0;
   logic [1:0] data_in0;
   logic       ready0;
   logic       valid_in1;
   logic [1:0] data_in1;
   logic       ready1;
   logic       ready_out;
   logic       valid_out;
   logic [1:0] data_out;
   logic       selector;
`ifdef ARB_CONT_EN
   logic [3:0] cont_grant0;
   logic [3:0] cont_grant1;

   modport slave (
      input  valid_in0, data_in0, valid_in1, data_in1, ready_out,
      output ready0, ready1, valid_out, data_out, selector, cont_grant0, cont_grant1
   );
   modport master (
      output valid_in0, data_in0, valid_in1, data_in1, ready_out,
      input  ready0, ready1, valid_out, data_out, selector, cont_grant0, cont_grant1
   );
`else
   modport slave (
      input  valid_in0, data_in0, valid_in1, data_in1, ready_out,
      output ready0, ready1, valid_out, data_out, selector
   );
   modport master (
      output valid_in0, data_in0, valid_in1, data_in1, ready_out,
      input  ready0, ready1, valid_out, data_out, selector
   );
`endif
endinterface

// File: rtl/arbitro_mux_rr.sv
// Round-robin arbiter feeding one registered 2-bit output from two lanes, with bounded bursts.
// Define ARB_CONT_EN to add the saturating per-lane accepted-beat counters cont_grant0/cont_grant1.
module arbitro_mux_rr #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
) (
   input logic            clk,
   input logic            reset,
   arbitro_mux_rr_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERV0 = 2'd1,
      SERV1 = 2'd2
   } state_t;

   state_t           state_q;
   logic             last_grant_q;
   logic             selector_q;
   logic             valid_out_q;
   logic [1:0]       data_out_q;
   logic [CNT_W-1:0] burst_cnt_q;

   logic             out_free_s;
   logic             ready0_s;
   logic             ready1_s;
   logic             acc0_s;
   logic             acc1_s;
   logic             accept_s;
   logic [1:0]       acc_data_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             burst_end_s;
   logic             cur_s;
   logic             own_valid_s;
   logic             other_valid_s;
   logic             switch_s;
   logic             target_s;
   logic             go_idle_s;

   // Handshake, accept and burst-limit terms derived from the current state.
   always_comb begin
      out_free_s    = !valid_out_q || bus.ready_out;
      ready0_s      = (state_q == SERV0) && out_free_s;
      ready1_s      = (state_q == SERV1) && out_free_s;
      acc0_s        = ready0_s && bus.valid_in0;
      acc1_s        = ready1_s && bus.valid_in1;
      accept_s      = acc0_s || acc1_s;
      acc_data_s    = acc1_s ? bus.data_in1 : bus.data_in0;
      cnt_inc_s     = burst_cnt_q + CNT_W'(1);
      burst_end_s   = accept_s && (cnt_inc_s == CNT_W'(MAX_BURST));
      cur_s         = (state_q == SERV1);
      own_valid_s   = cur_s ? bus.valid_in1 : bus.valid_in0;
      other_valid_s = cur_s ? bus.valid_in0 : bus.valid_in1;
   end

   // Grant decision: switch_s grants lane target_s, go_idle_s drops back to IDLE.
   always_comb begin
      switch_s  = 1'b0;
      target_s  = 1'b0;
      go_idle_s = 1'b0;
      case (state_q)
         IDLE: begin
            switch_s = bus.valid_in0 || bus.valid_in1;
            if (bus.valid_in0 && bus.valid_in1) begin
               target_s = !last_grant_q;
            end else begin
               target_s = bus.valid_in1;
            end
         end
         SERV0, SERV1: begin
            target_s = !cur_s;
            if (burst_end_s) begin
               switch_s = other_valid_s;
            end else if (!accept_s && !own_valid_s) begin
               switch_s  = other_valid_s;
               go_idle_s = !other_valid_s;
            end else begin
               switch_s  = 1'b0;
               go_idle_s = 1'b0;
            end
         end
         default: begin
            switch_s  = 1'b0;
            target_s  = 1'b0;
            go_idle_s = 1'b1;
         end
      endcase
   end

   // FSM, grant bookkeeping and the registered output beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         selector_q   <= 1'b0;
         valid_out_q  <= 1'b0;
         data_out_q   <= 2'b00;
         burst_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         if (accept_s) begin
            data_out_q  <= acc_data_s;
            valid_out_q <= 1'b1;
         end else if (bus.ready_out) begin
            valid_out_q <= 1'b0;
         end else begin
            valid_out_q <= valid_out_q;
         end

         if (switch_s) begin
            state_q      <= target_s ? SERV1 : SERV0;
            selector_q   <= target_s;
            last_grant_q <= target_s;
            burst_cnt_q  <= {CNT_W{1'b0}};
         end else if (go_idle_s) begin
            state_q <= IDLE;
         end else if (burst_end_s) begin
            burst_cnt_q <= {CNT_W{1'b0}};
         end else if (accept_s) begin
            burst_cnt_q <= cnt_inc_s;
         end else begin
            burst_cnt_q <= burst_cnt_q;
         end
      end
   end

   assign bus.ready0    = ready0_s;
   assign bus.ready1    = ready1_s;
   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;
   assign bus.selector  = selector_q;

`ifdef ARB_CONT_EN
   logic [3:0] cont0_q;
   logic [3:0] cont1_q;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
      if (en && (v != 4'hF)) begin
         return v + 4'd1;
      end else begin
         return v;
      end
   endfunction

   // Per-lane accepted-beat counters, sticking at 4'hF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cont0_q <= 4'h0;
         cont1_q <= 4'h0;
      end else begin
         cont0_q <= sat_inc(cont0_q, acc0_s);
         cont1_q <= sat_inc(cont1_q, acc1_s);
      end
   end

   assign bus.cont_grant0 = cont0_q;
   assign bus.cont_grant1 = cont1_q;
`endif

endmodule

// File: tb/tb_arbitro_mux_rr.sv
// Directed + random bench for arbitro_mux_rr against a cycle-level behavioural reference.
module tb_arbitro_mux_rr;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   arbitro_mux_rr_if bus();

   arbitro_mux_rr #(.MAX_BURST(MB), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: owner -1 means nobody holds the grant.
   int m_owner, m_last, m_beats, m_sel, m_vout, m_dout, m_acc_lane;
   int m_cnt[2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 1; m_beats = 0; m_sel = 0;
      m_vout = 0; m_dout = 0; m_acc_lane = -1;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic grant(input int k);
      m_owner = k; m_last = k; m_sel = k; m_beats = 0;
   endtask

   task automatic model_update(input int v0, input int v1, input int d0, input int d1, input int rout);
      int v[2];
      int d[2];
      int n, o;
      bit acc;
      v[0] = v0; v[1] = v1; d[0] = d0; d[1] = d1;
      n = m_owner; acc = 1'b0; m_acc_lane = -1;
      if (n >= 0) acc = (v[n] != 0) && (m_vout == 0 || rout != 0);
      if (acc) begin
         m_dout = d[n]; m_vout = 1; m_acc_lane = n;
         if (m_cnt[n] < 15) m_cnt[n]++;
      end else if (rout != 0) begin
         m_vout = 0;
      end
      if (n < 0) begin
         if (v[0] != 0 && v[1] != 0) grant(1 - m_last);
         else if (v[0] != 0) grant(0);
         else if (v[1] != 0) grant(1);
      end else begin
         o = 1 - n;
         if (acc) begin
            m_beats++;
            if (m_beats == MB) begin
               m_beats = 0;
               if (v[o] != 0) grant(o);
            end
         end else if (v[n] == 0) begin
            if (v[o] != 0) grant(o);
            else m_owner = -1;
         end
      end
   endtask

   task automatic check_outputs(input string ph);
      logic e0, e1;
      e0 = (m_owner == 0) && (m_vout == 0 || bus.ready_out);
      e1 = (m_owner == 1) && (m_vout == 0 || bus.ready_out);
      chk({ph, "_ready0"},    8'(bus.ready0),    8'(e0));
      chk({ph, "_ready1"},    8'(bus.ready1),    8'(e1));
      chk({ph, "_valid_out"}, 8'(bus.valid_out), 8'(m_vout));
      chk({ph, "_data_out"},  8'(bus.data_out),  8'(m_dout));
      chk({ph, "_selector"},  8'(bus.selector),  8'(m_sel));
`ifdef ARB_CONT_EN
      chk({ph, "_cont0"}, 8'(bus.cont_grant0), 8'(m_cnt[0]));
      chk({ph, "_cont1"}, 8'(bus.cont_grant1), 8'(m_cnt[1]));
`endif
   endtask

   // One clock: settle, compare, advance the reference with the inputs seen at the edge.
   task automatic step(input string ph);
      int v0, v1, d0, d1, ro, rs;
      #1;
      check_outputs(ph);
      v0 = int'(bus.valid_in0); v1 = int'(bus.valid_in1);
      d0 = int'(bus.data_in0);  d1 = int'(bus.data_in1);
      ro = int'(bus.ready_out); rs = int'(reset);
      @(posedge clk);
      if (rs != 0) model_reset();
      else model_update(v0, v1, d0, d1, ro);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [1:0] d0, input logic v1, input logic [1:0] d1, input logic ro);
      bus.valid_in0 = v0; bus.data_in0 = d0;
      bus.valid_in1 = v1; bus.data_in1 = d1;
      bus.ready_out = ro;
   endtask

   initial begin
      logic [1:0] seq [5];
      int idx;
      int guard;
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00; seq[4] = 2'b01;
      model_reset();

      // Reset held for two cycles under random inputs.
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         step("rst");
      end
      reset = 1'b0;

      // Single requester streaming five beats.
      idx = 0;
      guard = 0;
      while (idx < 5 && guard < 20) begin
         drive(1'b1, seq[idx], 1'b0, 2'b00, 1'b1);
         step("single");
         if (m_acc_lane == 0) idx++;
         guard++;
      end
      chk("single_done", 8'(idx), 8'd5);
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
      step("single_drop");
      step("single_idle");

      // Both requesters saturating: alternating bursts.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1);
         step("alt");
      end

      // Backpressure mid-burst.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1);
         step("bp_pre");
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b0);
         step("bp_hold");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1);
         step("bp_post");
      end

      // Asynchronous reset while lane 1 owns the grant.
      guard = 0;
      while (m_owner != 1 && guard < 20) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1);
         step("to_serv1");
         guard++;
      end
      chk("reached_serv1", 8'(m_owner), 8'd1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_outputs("async_rst");
      step("async_rst_hold");
      #2;
      reset = 1'b0;
      drive(1'b1, 2'b10, 1'b1, 2'b01, 1'b1);
      step("post_rst_bubble");
      chk("post_rst_first_grant", 8'(bus.selector), 8'd0);
      for (int i = 0; i < 6; i++) step("post_rst");

`ifdef ARB_CONT_EN
      // Long saturating run drives both counters to their ceiling.
      for (int i = 0; i < 45; i++) begin
         drive(1'b1, 2'($urandom), 1'b1, 2'($urandom), 1'b1);
         step("sat");
      end
      chk("cont0_saturated", 8'(bus.cont_grant0), 8'hF);
      chk("cont1_saturated", 8'(bus.cont_grant1), 8'hF);
`endif

      // Random traffic with random backpressure.
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0),
               2'($urandom), 1'($urandom_range(0, 2) != 0));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
